// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, writeback, issue and scoreboard status.
// Decode/writeback side is the master; the register file is the slave.
interface regfile_sb_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int MAXOUT = 3
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  issue_en;
    logic [AW-1:0]         issue_addr;
    logic                  issue_ok;
    logic                  flush;
    logic                  sb_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output issue_en, issue_addr, flush,
        input  rd_data, rd_busy, issue_ok, sb_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  issue_en, issue_addr, flush,
        output rd_data, rd_busy, issue_ok, sb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and a per-register
// scoreboard of outstanding writes for RAW hazard detection.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int MAXOUT = 3
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(MAXOUT + 1);

    logic [XLEN-1:0]  mem [NREGS];
    logic [CW-1:0]    cnt [NREGS];
    logic             err;
    logic             issue_ok;
    logic [NREGS-1:1] inc;
    logic [NREGS-1:1] dec;

    // A full register stays full even if it retires this cycle
    assign issue_ok = (bus.issue_addr == '0) ||
                      (cnt[bus.issue_addr] != CW'(MAXOUT));
    assign bus.issue_ok = issue_ok;
    assign bus.sb_err   = err;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        logic          ret;
        logic [CW-1:0] eff;

        assign a   = bus.rd_addr[i*AW +: AW];
        assign hit = bus.wr_en && (bus.wr_addr == a);
        assign ret = hit && (cnt[a] != '0);
        assign eff = cnt[a] - CW'(ret);

        assign bus.rd_data[i*XLEN +: XLEN] =
            (a == '0) ? '0 :
            hit       ? bus.wr_data :
                        mem[a];
        assign bus.rd_busy[i] = (a != '0) && (eff != '0);
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc[r] = bus.issue_en && issue_ok &&
                     (bus.issue_addr == AW'(r));
            dec[r] = bus.wr_en && (bus.wr_addr == AW'(r)) &&
                     (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            err <= 1'b0;
        end else begin
            if (bus.wr_en && bus.wr_addr != '0) begin
                mem[bus.wr_addr] <= bus.wr_data;
                // A flush absorbs the retire, so an empty count is not an error
                if (cnt[bus.wr_addr] == '0 && !bus.flush)
                    err <= 1'b1;
            end
            for (int r = 1; r < NREGS; r++) begin
                if (bus.flush)
                    cnt[r] <= '0;
                else if (inc[r] && !dec[r])
                    cnt[r] <= cnt[r] + CW'(1);
                else if (dec[r] && !inc[r])
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's two-port register bank, built for the pipelined datapath.
- Configurable data width, register count and number of read ports.
- Registers are written on the posedge, with combinational write-to-read bypass in the same cycle.
- A per-register scoreboard counts outstanding (issued but not written back) writes, so the hazard unit can detect RAW hazards and stall decode.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, ≥2). AW = $clog2(NREGS) is derived, not overridable.
- NREAD, 2, number of read ports (≥1).
- MAXOUT, 3, maximum outstanding writes per register (≥1). CW = $clog2(MAXOUT+1) is the counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset: synchronous, active-high. Clock is clk.
- rd_addr  in  NREAD*AW  read addresses; port i occupies [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data, combinational, port i at [i*XLEN +: XLEN].
- rd_busy  out  NREAD  port i register has a pending write not satisfied by the current bypass.
- wr_en  in  1  writeback strobe; also retires one outstanding write.
- wr_addr  in  AW  writeback register.
- wr_data  in  XLEN  writeback data.
- issue_en  in  1  decode issues an instruction that will write issue_addr.
- issue_addr  in  AW  destination of the issued instruction.
- issue_ok  out  1  issue is accepted this cycle.
- flush  in  1  clear all outstanding counts (pipeline flush).
- sb_err  out  1  sticky: a retire occurred on a register whose count was 0.

Behaviour:
- Reset (rst high at posedge):
  - All registers are cleared to 0, all counters to 0, and sb_err to 0.
  - After reset: rd_data = 0 on every port, rd_busy = 0, issue_ok = 1.
  - Reset overrides flush, write and issue in the same cycle.
- Register 0:
  - Reads always return 0 and never report busy.
  - Writes to register 0 are dropped.
  - Issue to register 0 is always accepted and never counted.
  - Retire to register 0 never sets sb_err.
- Write: at posedge, if wr_en and wr_addr != 0, then mem[wr_addr] <= wr_data. Single write port.
- Read (combinational, zero latency): rd_data_i is
  - 0 if rd_addr_i == 0;
  - else wr_data if wr_en and wr_addr == rd_addr_i;
  - else mem[rd_addr_i].
- Busy: rd_busy_i = (rd_addr_i != 0) and (eff_cnt[rd_addr_i] != 0), where eff_cnt = cnt minus 1 if a retire hits that register this cycle, else cnt.
  - Only the latest outstanding write clears busy through the bypass.
  - Issue in the same cycle does not affect rd_busy.
- issue_ok = (issue_addr == 0) or (cnt[issue_addr] != MAXOUT).
  - A retire in the same cycle to the same register does not free a slot early.
  - issue_ok is combinational.
- Counter update at posedge, per register r != 0:
  - inc = issue_en and issue_ok and issue_addr == r.
  - dec = wr_en and wr_addr == r and cnt[r] != 0.
  - inc and dec together leave the counter unchanged; inc alone adds 1; dec alone subtracts 1.
  - A counter never exceeds MAXOUT and never goes below 0.
- Error: wr_en with wr_addr != 0 and cnt[wr_addr] == 0 sets sb_err = 1. The data write still occurs. sb_err clears only on rst.
- flush:
  - All counters go to 0 at the next posedge and issue is ignored that cycle.
  - A write in the same cycle still updates data; its retire is absorbed with no sb_err.
  - issue_ok is still computed normally during a flush cycle.
- Multiple read ports may alias the same address, or the write address, and get identical values.

Test Plan:
- Reset then read all ports at addresses 0, 5 and 31 → rd_data = 0, rd_busy = 0, issue_ok = 1, sb_err = 0.
- Write x5 = 0xDEADBEEF with rd_addr0 = 5 in the same cycle → rd_data0 = 0xDEADBEEF (bypass). Next cycle, with wr_en low → still 0xDEADBEEF. Write x0 = 0x1234 → x0 reads 0.
- Issue x7 three times with MAXOUT = 3 → cnt = 3; a fourth issue sees issue_ok = 0 and cnt stays 3. Same-cycle retire x7 plus issue x7 while cnt = 3 → issue_ok = 0, cnt becomes 2.
- Issue x9 once, then retire x9 with rd_addr1 = 9 → rd_busy1 = 0 and rd_data1 = wr_data that cycle; cnt = 0 after. With two outstanding, the first retire leaves rd_busy1 = 1.
- Retire x3 with cnt = 0 → sb_err = 1 and x3 updated; sb_err stays 1 until rst.
- Issue x4 and x6, then flush together with issue x8 and write x4 = 0x55 → next cycle all counts 0 (x8 not counted), x4 = 0x55, sb_err = 0. Reset mid-sequence with cnt[4] = 2 → counts and data are 0 next cycle.
